// File: rtl/sram_reader_pkg.sv
// Shared types and constants for the SRAM stream reader.
package sram_reader_pkg;
  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [3:0] BE_ALL = 4'b1111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN
  } state_e;
endpackage

// File: rtl/sram_reader_fifo.sv
// Registered synchronous FIFO (no fall-through) with occupancy count.
module sram_reader_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != '0);
  // a push into a full FIFO is fine when the same cycle frees a slot
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign valid   = (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/avm_sram_stream_reader.sv
// Avalon-MM read master that streams consecutive SRAM words through a FIFO.
// Define SRAM_READER_LOOP_EN for continuous rescanning of the latched region.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing paced reads while credit allows
// DRAIN | all reads issued, waiting for the last word to land in the FIFO
module avm_sram_stream_reader
  import sram_reader_pkg::*;
#(
  parameter int ACCESS_CYCLES = 3,
  parameter int READ_LATENCY  = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int LEN_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);
  localparam int GAP_W  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH+1);
  localparam int PIPE_W = READ_LATENCY + 1;
  localparam int INF_W  = $clog2(PIPE_W+1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ACCESS_CYCLES-1);

  state_e            state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap;
  logic [PIPE_W-1:0] pipe;
  logic [INF_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [ADDR_W-1:0] start_addr;
  logic              issue;
  logic              push;
  logic              last_push;
  logic              base_lsb_unused;

`ifdef SRAM_READER_LOOP_EN
  logic [ADDR_W-1:0] loop_addr;
  logic [LEN_W-1:0]  loop_len;
`endif

  assign start_addr      = {base_addr[ADDR_W-1:2], 2'b00};
  assign base_lsb_unused = ^base_addr[1:0];

  // stage 0 of the pipe is the strobe itself; the last stage marks readdata valid
  assign avm_read  = pipe[0];
  assign push      = pipe[PIPE_W-1];
  assign last_push = (state == DRAIN) && push && (inflight == INF_W'(1));

  always_comb begin
    issue = (state == ISSUE) && (gap == '0) &&
            ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      gap            <= '0;
      pipe           <= '0;
      inflight       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_address    <= '0;
      avm_byteenable <= '0;
`ifdef SRAM_READER_LOOP_EN
      loop_addr      <= '0;
      loop_len       <= '0;
`endif
    end else begin
      done           <= 1'b0;
      pipe           <= {pipe[PIPE_W-2:0], issue};
      inflight       <= inflight + INF_W'(issue) - INF_W'(push);
      avm_byteenable <= issue ? BE_ALL : 4'b0000;

      if (issue) begin
        gap         <= GAP_LOAD;
        avm_address <= addr;
        addr        <= addr + ADDR_W'(WORD_BYTES);
        remaining   <= remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) state <= DRAIN;
      end else if (gap != '0) begin
        gap <= gap - GAP_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr      <= start_addr;
              remaining <= length;
              busy      <= 1'b1;
              state     <= ISSUE;
`ifdef SRAM_READER_LOOP_EN
              loop_addr <= start_addr;
              loop_len  <= length;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (last_push) begin
            done <= 1'b1;
`ifdef SRAM_READER_LOOP_EN
            addr      <= loop_addr;
            remaining <= loop_len;
            state     <= ISSUE;
`else
            busy      <= 1'b0;
            state     <= IDLE;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  sram_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(avm_readdata),
    .pop  (st_valid & st_ready),
    .rdata(st_data),
    .valid(st_valid),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_avm_sram_stream_reader.sv
// Self-checking bench: reader plus a behavioural SRAM controller stand-in.
`timescale 1ns/1ps
module tb_avm_sram_stream_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [17:0] base_addr;
  logic [15:0] length;
  logic        busy, done, avm_read, st_valid, st_ready;
  logic [17:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata, st_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [0:65535];
  logic [31:0] rd_s1 = '0, rd_s2 = '0;

  logic [31:0] got_data[$];
  logic [17:0] got_addr[$];
  int          got_cyc[$];
  int          done_cnt, busy_seen, be_bad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  avm_sram_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_readdata(avm_readdata), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready)
  );

  // controller: read sampled at edge E, data valid up to edge E+2
  always @(posedge clk) begin
    rd_s1 <= avm_read ? mem[avm_address[17:2]] : 32'h0;
    rd_s2 <= rd_s1;
  end
  assign avm_readdata = rd_s2;

  always @(negedge clk) begin
    if (!reset) begin
      if (avm_read) begin
        got_addr.push_back(avm_address);
        got_cyc.push_back(cyc);
        if (avm_byteenable !== 4'hf) be_bad++;
      end else if (avm_byteenable !== 4'h0) be_bad++;
      if (st_valid && st_ready) got_data.push_back(st_data);
      if (done) done_cnt++;
      if (busy) busy_seen++;
    end
  end

  function automatic logic [31:0] exp_word(input logic [17:0] b, input int i);
    logic [15:0] w;
    w = b[17:2] + 16'(i);
    return mem[w];
  endfunction

  function automatic logic [17:0] exp_addr(input logic [17:0] b, input int i);
    return {b[17:2], 2'b00} + 18'(4 * i);
  endfunction

  task automatic clear_obs();
    got_data.delete(); got_addr.delete(); got_cyc.delete();
    done_cnt = 0; busy_seen = 0; be_bad = 0;
  endtask

  task automatic do_start(input logic [17:0] b, input logic [15:0] l);
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit ok);
    int k = 0;
    while (got_data.size() < n && k < budget) begin
      @(posedge clk); k++;
    end
    ok = (got_data.size() >= n);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; st_ready = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (avm_read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", avm_read); end
    checks++; if (avm_address !== 18'h0) begin errors++; $display("FAIL reset_addr got %h want 0", avm_address); end
    checks++; if (avm_byteenable !== 4'h0) begin errors++; $display("FAIL reset_be got %h want 0", avm_byteenable); end
    checks++; if (st_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", st_valid); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    mem[0] = 32'hcccc0123; mem[1] = 32'hbbbbaaaa; mem[2] = 32'h12344567; mem[3] = 32'h0000abcd;
    clear_obs(); st_ready = 1'b1;
    do_start(18'h0, 16'd4);
    repeat (2) @(posedge clk);
    #1 base_addr = 18'h400; length = 16'd3; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_words(4, 200, ok);
    repeat (12) @(posedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d words want 4", got_data.size()); end
    checks++; if (got_data.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", got_data.size()); end
    checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL basic_reads got %0d want 4", got_addr.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_word(18'h0, i)) begin
        errors++; $display("FAIL basic_data[%0d] got %h want %h", i, got_data[i], exp_word(18'h0, i)); end
    end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++; if (got_cyc[i] - got_cyc[i-1] != 3) begin
        errors++; $display("FAIL basic_spacing[%0d] got %0d want 3", i, got_cyc[i] - got_cyc[i-1]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    checks++; if (be_bad != 0) begin errors++; $display("FAIL basic_byteenable got %0d bad want 0", be_bad); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int held_bad = 0;
    logic [17:0] b;
    b = {$urandom_range(0, 65535), 2'b00};
    b = b[17:0];
    clear_obs(); st_ready = 1'b0;
    do_start(b, 16'd16);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (st_valid && st_data !== exp_word(b, 0)) held_bad++;
    end
    checks++; if (got_addr.size() != 8) begin errors++; $display("FAIL bp_reads_stalled got %0d want 8", got_addr.size()); end
    checks++; if (st_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", st_valid); end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL bp_data_held got %0d unstable want 0", held_bad); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy got %b want 1", busy); end
    @(posedge clk); #1 st_ready = 1'b1;
    wait_words(16, 400, ok);
    repeat (12) @(posedge clk);
    checks++; if (got_data.size() != 16) begin errors++; $display("FAIL bp_count got %0d want 16", got_data.size()); end
    for (int i = 0; i < 16 && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== exp_word(b, i)) begin
        errors++; $display("FAIL bp_data[%0d] got %h want %h", i, got_data[i], exp_word(b, i)); end
    end
    for (int i = 0; i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== exp_addr(b, i)) begin
        errors++; $display("FAIL bp_addr[%0d] got %h want %h", i, got_addr[i], exp_addr(b, i)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_obs(); st_ready = 1'b1;
    do_start(18'h3fffc, 16'd2);
    wait_words(2, 200, ok);
    repeat (8) @(posedge clk);
    checks++; if (got_addr.size() != 2) begin errors++; $display("FAIL wrap_reads got %0d want 2", got_addr.size()); end
    else begin
      checks++; if (got_addr[0] !== 18'h3fffc) begin errors++; $display("FAIL wrap_addr0 got %h want 3fffc", got_addr[0]); end
      checks++; if (got_addr[1] !== 18'h00000) begin errors++; $display("FAIL wrap_addr1 got %h want 00000", got_addr[1]); end
    end
    checks++; if (got_data.size() != 2) begin errors++; $display("FAIL wrap_count got %0d want 2", got_data.size()); end
    else begin
      checks++; if (got_data[1] !== mem[0]) begin errors++; $display("FAIL wrap_data1 got %h want %h", got_data[1], mem[0]); end
    end
    clear_obs();
    do_start(18'h21, 16'd1);
    wait_words(1, 200, ok);
    repeat (8) @(posedge clk);
    checks++; if (got_addr.size() != 1 || got_addr[0] !== 18'h20) begin
      errors++; $display("FAIL align_addr got %0d reads first %h want 1 read at 00020", got_addr.size(),
                         got_addr.size() > 0 ? got_addr[0] : 18'h0); end
    checks++; if (got_data.size() != 1 || got_data[0] !== mem[8]) begin
      errors++; $display("FAIL align_data got %0d words want 1 of %h", got_data.size(), mem[8]); end
  endtask

  task automatic test_zero_len();
    clear_obs();
    @(posedge clk); #1 base_addr = 18'h100; length = 16'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_next got %b want 1", done); end
    repeat (10) @(posedge clk);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count got %0d want 1", done_cnt); end
    checks++; if (got_addr.size() != 0) begin errors++; $display("FAIL zero_reads got %0d want 0", got_addr.size()); end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL zero_busy got %0d cycles want 0", busy_seen); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    mem[8] = 32'hdeadbeef;
    clear_obs(); st_ready = 1'b1;
    do_start(18'h100, 16'd16);
    while (got_addr.size() < 3 && k < 100) begin @(negedge clk); k++; end
    checks++; if (got_addr.size() < 3) begin errors++; $display("FAIL rmid_timeout got %0d reads want 3", got_addr.size()); end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done, avm_read, avm_address, avm_byteenable, st_valid} !== 26'h0) begin
      errors++; $display("FAIL rmid_outputs got busy=%b done=%b rd=%b addr=%h be=%h valid=%b want all 0",
                         busy, done, avm_read, avm_address, avm_byteenable, st_valid); end
    @(posedge clk); #1 reset = 1'b0;
    clear_obs();
    do_start(18'h20, 16'd1);
    wait_words(1, 200, ok);
    repeat (12) @(posedge clk);
    checks++; if (got_data.size() != 1) begin errors++; $display("FAIL rmid_count got %0d want 1", got_data.size()); end
    else begin
      checks++; if (got_data[0] !== 32'hdeadbeef) begin errors++; $display("FAIL rmid_data got %h want deadbeef", got_data[0]); end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      logic [17:0] b;
      int len, k, sp_bad;
      b = 18'($urandom);
      len = $urandom_range(1, 24);
      sp_bad = 0;
      clear_obs(); st_ready = 1'b1;
      do_start(b, 16'(len));
      k = 0;
      while ((got_data.size() < len || busy) && k < 2000) begin
        @(posedge clk); #1 st_ready = ($urandom_range(0, 3) != 0); k++;
      end
      st_ready = 1'b1;
      repeat (12) @(posedge clk);
      checks++; if (got_data.size() != len) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", t, got_data.size(), len); end
      for (int i = 0; i < len && i < got_data.size(); i++) begin
        checks++; if (got_data[i] !== exp_word(b, i)) begin
          errors++; $display("FAIL rnd%0d_data[%0d] got %h want %h", t, i, got_data[i], exp_word(b, i)); end
      end
      for (int i = 0; i < got_addr.size(); i++) begin
        checks++; if (got_addr[i] !== exp_addr(b, i)) begin
          errors++; $display("FAIL rnd%0d_addr[%0d] got %h want %h", t, i, got_addr[i], exp_addr(b, i)); end
        if (i > 0 && got_cyc[i] - got_cyc[i-1] < 3) sp_bad++;
      end
      checks++; if (sp_bad != 0) begin errors++; $display("FAIL rnd%0d_spacing got %0d short gaps want 0", t, sp_bad); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done got %0d want 1", t, done_cnt); end
    end
  endtask

`ifdef SRAM_READER_LOOP_EN
  task automatic test_loop();
    bit ok;
    clear_obs(); st_ready = 1'b1;
    do_start(18'h0, 16'd2);
    for (int p = 0; p < 3; p++) begin
      repeat (4) @(posedge clk);
      #1 base_addr = 18'h440; length = 16'd5; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_words(8, 400, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL loop_timeout got %0d words want 8", got_data.size()); end
    for (int i = 0; i < 8 && i < got_data.size(); i++) begin
      checks++; if (got_data[i] !== mem[i % 2]) begin
        errors++; $display("FAIL loop_data[%0d] got %h want %h", i, got_data[i], mem[i % 2]); end
    end
    for (int i = 0; i < got_addr.size(); i++) begin
      checks++; if (got_addr[i] !== 18'(4 * (i % 2))) begin
        errors++; $display("FAIL loop_addr[%0d] got %h want %h", i, got_addr[i], 18'(4 * (i % 2))); end
    end
    checks++; if (done_cnt < 4) begin errors++; $display("FAIL loop_done got %0d want >=4", done_cnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy got %b want 1", busy); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    clear_obs();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    test_random();
`ifdef SRAM_READER_LOOP_EN
    test_loop();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
